// File: rtl/ps2_cursor_ctrl_pkg.sv
// Shared constants for the Bingo board PS/2 input path: the scan codes this
// block reacts to, the grid size default shared with the VGA display path,
// and the receiver state encoding.
package ps2_cursor_ctrl_pkg;

  // Grid side length; the display path uses the same value.
  localparam int GRID_N_DEF = 5;

  // Device->host idle gap after which a partial frame is dropped (2 ms @ 100 MHz).
  localparam int TIMEOUT_CYC_DEF = 200000;

  // Set-2 scan codes.
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_UP  = 8'h75;
  localparam logic [7:0] SC_DN  = 8'h72;
  localparam logic [7:0] SC_LT  = 8'h6B;
  localparam logic [7:0] SC_RT  = 8'h74;
  localparam logic [7:0] SC_ENT = 8'h5A;
  localparam logic [7:0] SC_SPC = 8'h29;

  // Frame receiver states.
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // Odd parity check over data byte plus parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device->host frame receiver.
// Synchronises PS2_CLK/PS2_DATA, detects falling edges of the PS/2 clock,
// assembles start/8 data/parity/stop frames and flags good bytes or bad
// frames with single-cycle pulses. A partial frame is silently abandoned when
// no falling edge arrives for TIMEOUT_CYC clock cycles.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (data low on a falling edge)
// RX_DATA   | shifting in D0..D7, LSB first
// RX_PARITY | capturing the parity bit
// RX_STOP   | checking stop bit and odd parity, then back to idle
module ps2_rx_frame
  import ps2_cursor_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;

  rx_state_e state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_vld_q, byte_vld_d;
  logic          ferr_q, ferr_d;

  // Two-flop synchronisers plus one delayed copy of the clock for edge detect.
  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // Frame state register and output pulse flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= TMO_LOAD;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic: advance one frame bit per falling edge; otherwise run
  // the inactivity down-counter while a frame is in progress.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    ferr_d     = 1'b0;

    if (fall) begin
      tmo_d = TMO_LOAD;
      case (state_q)
        RX_IDLE: begin
          // A high data bit here is line noise or a lost frame tail; ignore it.
          if (!data_sync_q) begin
            state_d  = RX_DATA;
            bitcnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d = {data_sync_q, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        RX_PARITY: begin
          par_d   = data_sync_q;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (data_sync_q && odd_parity_ok(shift_q, par_q)) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE) begin
      if (tmo_q == '0) begin
        state_d = RX_IDLE;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end
  end

  assign byte_vld_o  = byte_vld_q;
  assign byte_o      = byte_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/ps2_cursor_ctrl.sv
// PS/2 keyboard cursor controller for the Bingo board.
// Decodes make/break/extended scan codes from ps2_rx_frame, moves a cursor
// over the GRID_N x GRID_N grid with the arrow keys and emits a one-cycle
// select pulse with the cell index on Enter or Space.
// Build option: define CURSOR_WRAP_EN to make cursor moves wrap around the
// grid edges instead of saturating.
module ps2_cursor_ctrl
  import ps2_cursor_ctrl_pkg::*;
#(
  parameter int GRID_N      = GRID_N_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [2:0] cur_x,
  output logic [2:0] cur_y,
  output logic       sel_valid,
  output logic [4:0] sel_idx,
  output logic [7:0] key_code,
  output logic       frame_err
);

  localparam logic [2:0] MAX_POS = 3'(GRID_N - 1);
  localparam logic [4:0] GRID_W  = 5'(GRID_N);

  logic       rx_vld;
  logic [7:0] rx_byte;
  logic       rx_ferr;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] cur_x_q, cur_x_d;
  logic [2:0] cur_y_q, cur_y_d;
  logic       sel_valid_q, sel_valid_d;
  logic [4:0] sel_idx_q, sel_idx_d;
  logic [7:0] key_code_q, key_code_d;
  logic [4:0] idx_now;

  ps2_rx_frame #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (PS2_CLK),
    .ps2_data_i  (PS2_DATA),
    .byte_vld_o  (rx_vld),
    .byte_o      (rx_byte),
    .frame_err_o (rx_ferr)
  );

  function automatic logic [2:0] pos_dec(input logic [2:0] p);
`ifdef CURSOR_WRAP_EN
    return (p == 3'd0) ? MAX_POS : p - 3'd1;
`else
    return (p == 3'd0) ? p : p - 3'd1;
`endif
  endfunction

  function automatic logic [2:0] pos_inc(input logic [2:0] p);
`ifdef CURSOR_WRAP_EN
    return (p >= MAX_POS) ? 3'd0 : p + 3'd1;
`else
    return (p >= MAX_POS) ? p : p + 3'd1;
`endif
  endfunction

  assign idx_now = ({2'b00, cur_y_q} * GRID_W) + {2'b00, cur_x_q};

  // Decoder/cursor state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      key_code_q  <= '0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
      key_code_q  <= key_code_d;
    end
  end

  // Scan-code decode: prefixes set flags, releases are swallowed, makes act.
  // Select and move codes are disjoint, so one byte can never do both.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    sel_valid_d = 1'b0;
    sel_idx_d   = sel_idx_q;
    key_code_d  = key_code_q;

    if (rx_vld) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        key_code_d = rx_byte;
        ext_d      = 1'b0;
        if (rx_byte == SC_ENT || rx_byte == SC_SPC) begin
          sel_valid_d = 1'b1;
          sel_idx_d   = idx_now;
        end else if (ext_q) begin
          case (rx_byte)
            SC_UP:   cur_y_d = pos_dec(cur_y_q);
            SC_DN:   cur_y_d = pos_inc(cur_y_q);
            SC_LT:   cur_x_d = pos_dec(cur_x_q);
            SC_RT:   cur_x_d = pos_inc(cur_x_q);
            default: ;
          endcase
        end
      end
    end
  end

  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign sel_valid = sel_valid_q;
  assign sel_idx   = sel_idx_q;
  assign key_code  = key_code_q;
  assign frame_err = rx_ferr;

endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// Directed bench for ps2_cursor_ctrl: drives PS/2 frames bit by bit and
// checks cursor, key code, select and frame-error behaviour against
// hand-computed values.
module tb_ps2_cursor_ctrl;

  localparam int TMO = 400;

  logic       clk;
  logic       rst;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [2:0] cur_x;
  logic [2:0] cur_y;
  logic       sel_valid;
  logic [4:0] sel_idx;
  logic [7:0] key_code;
  logic       frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int sel_cnt     = 0;
  int sel_last    = 0;
  int ferr_cnt    = 0;

  ps2_cursor_ctrl #(
    .GRID_N      (5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx),
    .key_code  (key_code),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses away from the active edge.
  always @(negedge clk) begin
    if (sel_valid) begin
      sel_cnt  = sel_cnt + 1;
      sel_last = sel_idx;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors = vectors + 1;
    if (obs !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic d);
    PS2_DATA = d;
    tick(10);
    PS2_CLK = 1'b0;
    tick(20);
    PS2_CLK = 1'b1;
    tick(10);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    tick(20);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(5);
  endtask

  int s0, f0;
  int exp_x, exp_y, exp_idx;

  initial begin
    rst      = 1'b1;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(5);

    // Reset state
    chk("rst_cur_x", cur_x, 0);
    chk("rst_cur_y", cur_y, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_sel_idx", sel_idx, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_frame_err", frame_err, 0);

    // 1. right x2, down, then Enter selects cell 1*5+2 = 7
    send_good(8'hE0); send_good(8'h74);
    send_good(8'hE0); send_good(8'h74);
    send_good(8'hE0); send_good(8'h72);
    chk("t1_cur_x", cur_x, 2);
    chk("t1_cur_y", cur_y, 1);
    chk("t1_key_dn", key_code, 8'h72);
    s0 = sel_cnt;
    send_good(8'h5A);
    chk("t1_sel_cnt", sel_cnt - s0, 1);
    chk("t1_sel_idx", sel_last, 7);
    chk("t1_key_ent", key_code, 8'h5A);
    chk("t1_cur_x_hold", cur_x, 2);
    // Non-extended 75 is keypad 8, not an arrow: key code only
    send_good(8'h75);
    chk("t1_noext_y", cur_y, 1);
    chk("t1_noext_key", key_code, 8'h75);

    // 2. Edge behaviour from (0,0)
    do_reset();
    send_good(8'hE0); send_good(8'h75);
    send_good(8'hE0); send_good(8'h6B);
`ifdef CURSOR_WRAP_EN
    exp_x = 4; exp_y = 4;
`else
    exp_x = 0; exp_y = 0;
`endif
    chk("t2_up_edge_y", cur_y, exp_y);
    chk("t2_lt_edge_x", cur_x, exp_x);
    for (int i = 0; i < 6; i++) begin
      send_good(8'hE0); send_good(8'h74);
    end
`ifdef CURSOR_WRAP_EN
    exp_x = 0; exp_idx = 20;
`else
    exp_x = 4; exp_idx = 4;
`endif
    chk("t2_rt_x6", cur_x, exp_x);
    s0 = sel_cnt;
    send_good(8'h5A);
    chk("t2_sel_cnt", sel_cnt - s0, 1);
    chk("t2_sel_idx", sel_last, exp_idx);

    // 3. Break codes: no select, no move, key code held
    s0 = sel_cnt;
    send_good(8'hF0); send_good(8'h5A);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h74);
    chk("t3_sel_cnt", sel_cnt - s0, 0);
    chk("t3_cur_x", cur_x, exp_x);
    chk("t3_cur_y", cur_y, exp_y);
    chk("t3_key", key_code, 8'h5A);

    // 4. Bad parity drops the frame; the next good Space selects
    s0 = sel_cnt; f0 = ferr_cnt;
    send_byte(8'h5A, 1'b1);
    chk("t4_ferr_cnt", ferr_cnt - f0, 1);
    chk("t4_sel_none", sel_cnt - s0, 0);
    send_good(8'h29);
    chk("t4_sel_spc", sel_cnt - s0, 1);
    chk("t4_key_spc", key_code, 8'h29);
    chk("t4_idx_spc", sel_last, exp_idx);

    // 5. Stalled partial frame times out silently
    s0 = sel_cnt; f0 = ferr_cnt;
    send_partial(8'h5A, 4);
    tick(TMO + 600);
    send_good(8'h5A);
    chk("t5_sel_cnt", sel_cnt - s0, 1);
    chk("t5_ferr_cnt", ferr_cnt - f0, 0);
    chk("t5_key", key_code, 8'h5A);

    // 6. Reset mid-frame, then a clean down move
    f0 = ferr_cnt; s0 = sel_cnt;
    send_partial(8'h72, 6);
    rst = 1'b1;
    tick(3);
    chk("t6_rst_cur_x", cur_x, 0);
    chk("t6_rst_cur_y", cur_y, 0);
    chk("t6_rst_key", key_code, 0);
    chk("t6_rst_sel_idx", sel_idx, 0);
    chk("t6_rst_sel_valid", sel_valid, 0);
    chk("t6_rst_ferr", frame_err, 0);
    rst = 1'b0;
    tick(5);
    send_good(8'hE0); send_good(8'h72);
    chk("t6_cur_y", cur_y, 1);
    chk("t6_cur_x", cur_x, 0);
    chk("t6_key", key_code, 8'h72);
    chk("t6_ferr_cnt", ferr_cnt - f0, 0);
    chk("t6_sel_cnt", sel_cnt - s0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
